ber_window_meter: RTL and testbench

- Sits directly downstream of the PRBS-23 checker in the loopback test path; consumes its per-bit valid/error stream (oval/odgood).
- Measures bit errors over fixed windows of valid bits, latches the per-window result, keeps a saturating running total and raises a threshold alarm.
- Gives the modem bring-up bench a windowed BER figure that can be read out without stopping traffic.

---
 rtl/ber_window_meter.sv | 183 ++++++++++++++++++
 tb/tb_ber_window_meter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ber_window_meter.sv
// ber_window_meter
//
// Windowed bit-error-rate meter fed by the PRBS checker's valid/error stream.
// After a start it discards SETTLE valid bits so the checker can re-lock, then
// counts errors over back-to-back windows of 2^WIN_LOG2 valid bits. Each
// completed window latches its error count, adds it to a saturating running
// total, bumps a wrapping window counter and can set a sticky alarm.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   istart       pulse: start / restart measurement
//   istop        pulse: abort measurement, back to IDLE
//   icont        1 = continuous windows, 0 = single window (sampled at window end)
//   ival         bit valid from checker
//   ierr         bit error flag (qualified by ival)
//   ithr         per-window alarm threshold
//   o_err_win    error count of the last completed window
//   o_err_total  saturating error sum over completed windows since start
//   o_win_cnt    completed windows since start (wraps)
//   o_done       one-cycle pulse when o_err_win updates
//   o_alarm      sticky: some completed window exceeded ithr
//   o_busy       high while settling or measuring

module ber_window_meter #(
    parameter int WIN_LOG2 = 16,
    parameter int SETTLE   = 64,
    parameter int ERR_W    = 24,
    parameter int WCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              istart,
    input  logic              istop,
    input  logic              icont,
    input  logic              ival,
    input  logic              ierr,
    input  logic [ERR_W-1:0]  ithr,
    output logic [ERR_W-1:0]  o_err_win,
    output logic [ERR_W-1:0]  o_err_total,
    output logic [WCNT_W-1:0] o_win_cnt,
    output logic              o_done,
    output logic              o_alarm,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE
    } state_t;

    // Settle counter only needs to reach SETTLE-1; keep at least one bit so
    // the SETTLE=0 build still elaborates (the state is unreachable then).
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0]    SET_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [SET_W-1:0]    SET_ONE  = SET_W'(1);
    localparam logic [WIN_LOG2:0]   WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};
    localparam logic [WIN_LOG2:0]   BIT_ONE  = (WIN_LOG2 + 1)'(1);
    localparam logic [ERR_W-1:0]    ERR_MAX  = '1;
    localparam logic [ERR_W-1:0]    ERR_ONE  = ERR_W'(1);
    localparam logic [WCNT_W-1:0]   WCNT_ONE = WCNT_W'(1);
    localparam state_t START_STATE = (SETTLE == 0) ? ST_MEASURE : ST_SETTLE;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [WIN_LOG2:0]  bit_cnt_q, bit_cnt_d;
    logic [ERR_W-1:0]   acc_q, acc_d;
    logic [ERR_W-1:0]   err_win_q, err_win_d;
    logic [ERR_W-1:0]   err_total_q, err_total_d;
    logic [WCNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic               done_q, done_d;
    logic               alarm_q, alarm_d;

    logic [ERR_W-1:0]   acc_inc;
    logic [ERR_W:0]     total_sum;

    // Accumulator value including the current bit, and the running total with
    // that window added; the extra carry bit of total_sum flags saturation.
    always_comb begin
        acc_inc = acc_q;
        if (ierr && (acc_q != ERR_MAX)) begin
            acc_inc = acc_q + ERR_ONE;
        end
        total_sum = {1'b0, err_total_q} + {1'b0, acc_inc};
    end

    // Next-state logic. istop beats istart, and istart beats a window end, so
    // a restart landing on the last bit of a window produces no result.
    always_comb begin
        state_d     = state_q;
        set_cnt_d   = set_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        err_win_d   = err_win_q;
        err_total_d = err_total_q;
        win_cnt_d   = win_cnt_q;
        done_d      = 1'b0;
        alarm_d     = alarm_q;

        if (istop) begin
            state_d   = ST_IDLE;
            set_cnt_d = '0;
            bit_cnt_d = '0;
            acc_d     = '0;
        end else if (istart) begin
            state_d     = START_STATE;
            set_cnt_d   = '0;
            bit_cnt_d   = '0;
            acc_d       = '0;
            err_total_d = '0;
            win_cnt_d   = '0;
            alarm_d     = 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (ival) begin
                        if (set_cnt_q == SET_LAST) begin
                            state_d   = ST_MEASURE;
                            set_cnt_d = '0;
                        end else begin
                            set_cnt_d = set_cnt_q + SET_ONE;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (ival) begin
                        if (bit_cnt_q == WIN_LAST) begin
                            // Window end: the bit taken this cycle is included.
                            err_win_d   = acc_inc;
                            err_total_d = total_sum[ERR_W] ? ERR_MAX : total_sum[ERR_W-1:0];
                            win_cnt_d   = win_cnt_q + WCNT_ONE;
                            done_d      = 1'b1;
                            alarm_d     = alarm_q | (acc_inc > ithr);
                            bit_cnt_d   = '0;
                            acc_d       = '0;
                            state_d     = icont ? ST_MEASURE : ST_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                            acc_d     = acc_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and result registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            set_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            err_win_q   <= '0;
            err_total_q <= '0;
            win_cnt_q   <= '0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_cnt_q   <= set_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            err_win_q   <= err_win_d;
            err_total_q <= err_total_d;
            win_cnt_q   <= win_cnt_d;
            done_q      <= done_d;
            alarm_q     <= alarm_d;
        end
    end

    assign o_err_win   = err_win_q;
    assign o_err_total = err_total_q;
    assign o_win_cnt   = win_cnt_q;
    assign o_done      = done_q;
    assign o_alarm     = alarm_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ber_window_meter.sv
// tb_ber_window_meter
//
// Directed bench for ber_window_meter with a small build (16-bit windows,
// 2 settle bits). A second instance with 4-bit error counters shares the same
// stimulus and is only examined during the saturation scenario.

module tb_ber_window_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       istart = 1'b0;
    logic       istop = 1'b0;
    logic       icont = 1'b0;
    logic       ival = 1'b0;
    logic       ierr = 1'b0;
    logic [7:0] ithr = 8'd255;
    logic [3:0] ithr_sat = 4'hF;

    logic [7:0]  o_err_win, o_err_total;
    logic [15:0] o_win_cnt;
    logic        o_done, o_alarm, o_busy;

    logic [3:0]  s_err_win, s_err_total;
    logic [15:0] s_win_cnt;
    logic        s_done, s_alarm, s_busy;

    int passCount = 0;
    int checkCount = 0;

    ber_window_meter #(.WIN_LOG2(4), .SETTLE(2), .ERR_W(8), .WCNT_W(16)) dut (
        .clk(clk), .rst(rst), .istart(istart), .istop(istop), .icont(icont),
        .ival(ival), .ierr(ierr), .ithr(ithr),
        .o_err_win(o_err_win), .o_err_total(o_err_total), .o_win_cnt(o_win_cnt),
        .o_done(o_done), .o_alarm(o_alarm), .o_busy(o_busy)
    );

    ber_window_meter #(.WIN_LOG2(4), .SETTLE(2), .ERR_W(4), .WCNT_W(16)) dut_sat (
        .clk(clk), .rst(rst), .istart(istart), .istop(istop), .icont(icont),
        .ival(ival), .ierr(ierr), .ithr(ithr_sat),
        .o_err_win(s_err_win), .o_err_total(s_err_total), .o_win_cnt(s_win_cnt),
        .o_done(s_done), .o_alarm(s_alarm), .o_busy(s_busy)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Present one bit for one clock, then sample 1 ns after the edge.
    task automatic applyStimulus(input logic v, input logic e);
        ival = v;
        ierr = e;
        @(posedge clk);
        #1;
        ival = 1'b0;
        ierr = 1'b0;
    endtask

    // Single-cycle start / stop pulses with no valid bit alongside.
    task automatic pulseStart();
        istart = 1'b1;
        applyStimulus(1'b0, 1'b0);
        istart = 1'b0;
    endtask

    task automatic pulseStop();
        istop = 1'b1;
        applyStimulus(1'b0, 1'b0);
        istop = 1'b0;
    endtask

    // One comparison: count it, and report a miss with tag and both values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // The whole directed sequence, one scenario after another.
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_err_win", o_err_win, 0);
        checkOutput("rst_total", o_err_total, 0);
        checkOutput("rst_win_cnt", o_win_cnt, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_alarm", o_alarm, 0);
        checkOutput("rst_busy", o_busy, 0);
        rst = 1'b0;

        // Error-free single window: 2 settle bits + 16 measured bits
        $display("[TB] error-free single window");
        icont = 1'b0;
        ithr  = 8'd255;
        pulseStart();
        checkOutput("t1_busy_after_start", o_busy, 1);
        for (int i = 1; i <= 17; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("t1_no_done_bit17", o_done, 0);
        checkOutput("t1_busy_bit17", o_busy, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1_done", o_done, 1);
        checkOutput("t1_err_win", o_err_win, 0);
        checkOutput("t1_win_cnt", o_win_cnt, 1);
        checkOutput("t1_busy_dropped", o_busy, 0);
        checkOutput("t1_alarm", o_alarm, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t1_done_one_cycle", o_done, 0);
        checkOutput("t1_idle_ignores", o_win_cnt, 1);

        // Settle errors excluded, last bit of window included
        $display("[TB] settle and boundary errors");
        pulseStart();
        checkOutput("t2_cnt_cleared", o_win_cnt, 0);
        checkOutput("t2_err_win_held", o_err_win, 0);
        for (int i = 1; i <= 18; i++)
            applyStimulus(1'b1, (i == 1 || i == 2 || i == 3 || i == 18));
        checkOutput("t2_done", o_done, 1);
        checkOutput("t2_err_win", o_err_win, 2);
        checkOutput("t2_total", o_err_total, 2);

        // Continuous, throttled, alarm; junk ierr on invalid cycles
        $display("[TB] continuous mode with throttling");
        icont = 1'b1;
        ithr  = 8'd3;
        pulseStart();
        checkOutput("t3_total_cleared", o_err_total, 0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b1, (k == 1 || k == 5 || k == 9 || k == 16));
        end
        checkOutput("t3_w1_done", o_done, 1);
        checkOutput("t3_w1_err_win", o_err_win, 4);
        checkOutput("t3_w1_total", o_err_total, 4);
        checkOutput("t3_w1_alarm", o_alarm, 1);
        checkOutput("t3_w1_busy", o_busy, 1);
        // First valid bit of window 2 directly follows the window end
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b1, (k == 1));
            if (k == 1) checkOutput("t3_done_pulse_ends", o_done, 0);
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("t3_no_early_done", o_done, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_w2_done", o_done, 1);
        checkOutput("t3_w2_err_win", o_err_win, 1);
        checkOutput("t3_w2_total", o_err_total, 5);
        checkOutput("t3_w2_win_cnt", o_win_cnt, 2);
        checkOutput("t3_w2_alarm_sticky", o_alarm, 1);
        pulseStop();
        checkOutput("t3_stop_idle", o_busy, 0);

        // Saturation: every bit in error for two windows
        $display("[TB] saturation");
        pulseStart();
        for (int i = 1; i <= 18; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("t4_sat_w1_err_win", s_err_win, 15);
        checkOutput("t4_sat_w1_total", s_err_total, 15);
        checkOutput("t4_w1_err_win", o_err_win, 16);
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("t4_sat_w2_done", s_done, 1);
        checkOutput("t4_sat_w2_err_win", s_err_win, 15);
        checkOutput("t4_sat_w2_total", s_err_total, 15);
        checkOutput("t4_sat_w2_win_cnt", s_win_cnt, 2);
        checkOutput("t4_w2_total", o_err_total, 32);
        pulseStop();

        // Abort after 10 measured bits: nothing emitted, results held
        $display("[TB] aborts");
        icont = 1'b0;
        ithr  = 8'd0;
        pulseStart();
        checkOutput("t5_alarm_cleared", o_alarm, 0);
        for (int i = 1; i <= 12; i++) applyStimulus(1'b1, (i >= 3 && i <= 5));
        pulseStop();
        checkOutput("t5_stop_busy", o_busy, 0);
        checkOutput("t5_stop_no_done", o_done, 0);
        checkOutput("t5_stop_err_win_held", o_err_win, 16);
        checkOutput("t5_stop_win_cnt", o_win_cnt, 0);
        for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("t5_idle_no_done", o_done, 0);
        checkOutput("t5_idle_alarm", o_alarm, 0);

        // Restart coinciding with the 16th measured bit wins over window end
        pulseStart();
        for (int i = 1; i <= 17; i++) applyStimulus(1'b1, (i >= 3 && i <= 5));
        istart = 1'b1;
        applyStimulus(1'b1, 1'b1);
        istart = 1'b0;
        checkOutput("t5_restart_no_done", o_done, 0);
        checkOutput("t5_restart_err_win", o_err_win, 16);
        checkOutput("t5_restart_busy", o_busy, 1);
        for (int i = 1; i <= 17; i++) applyStimulus(1'b1, (i <= 2 || i == 9));
        checkOutput("t5_resettle_no_done", o_done, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_resettle_done", o_done, 1);
        checkOutput("t5_resettle_err_win", o_err_win, 1);
        checkOutput("t5_resettle_win_cnt", o_win_cnt, 1);
        checkOutput("t5_resettle_alarm", o_alarm, 1);

        // Asynchronous reset between edges while measuring
        $display("[TB] async reset mid-measure");
        icont = 1'b1;
        pulseStart();
        for (int i = 1; i <= 18; i++) applyStimulus(1'b1, (i == 10));
        checkOutput("t6_pre_err_win", o_err_win, 1);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_err_win", o_err_win, 0);
        checkOutput("t6_total", o_err_total, 0);
        checkOutput("t6_win_cnt", o_win_cnt, 0);
        checkOutput("t6_done", o_done, 0);
        checkOutput("t6_alarm", o_alarm, 0);
        checkOutput("t6_busy", o_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("t6_idle_after_rst", o_busy, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
